fp_alu_issue: RTL

FP_ALU_ISSUE -- requirements
Module: fp_alu_issue

---
 rtl/fp_alu_issue.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fp_alu_issue.sv
// Issue/response sequencer in front of a multi-cycle fp_alu: clears the ALU, issues one
// operation at a time, waits for completion or timeout, and holds the response until taken.
module fp_alu_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 63,
  parameter int unsigned CLR_CYCLES     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  output logic        alu_ce,
  output logic        alu_sclr,
  output logic [5:0]  alu_operation,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_rdy,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_tag,
  output logic        rsp_timeout,
  output logic        busy
);

  // Terminal counts are compared against the pre-increment counter value.
  localparam logic [7:0]  WaitLast = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  ClrLast  = 4'(CLR_CYCLES - 1);
  localparam logic [31:0] QNaN     = 32'h7FC0_0000;

  // StRst is the reset-pending state: everything idle, ALU clear not yet started.
  typedef enum logic [2:0] {
    StRst,
    StInit,
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  tag_q, tag_d;
  logic [31:0] res_q, res_d;
  logic        to_q, to_d;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    res_d      = res_q;
    to_d       = to_q;
    req_ready  = 1'b0;
    alu_ce     = 1'b0;
    alu_sclr   = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;

    unique case (state_q)
      StRst: begin
        clr_cnt_d = '0;
        state_d   = StInit;
      end

      StInit: begin
        alu_sclr = 1'b1;
        if (clr_cnt_q == ClrLast) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end

      StIdle: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          op_d       = req_op;
          a_d        = req_a;
          b_d        = req_b;
          tag_d      = req_tag;
          wait_cnt_d = '0;
          state_d    = StWait;
        end
      end

      StWait: begin
        alu_ce     = 1'b1;
        wait_cnt_d = wait_cnt_q + 8'd1;
        // A completion in the last allowed cycle still counts as a normal result.
        if (alu_rdy) begin
          res_d   = alu_result;
          to_d    = 1'b0;
          state_d = StResp;
        end else if (wait_cnt_q == WaitLast) begin
          res_d   = QNaN;
          to_d    = 1'b1;
          state_d = StResp;
        end
      end

      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          // After a timeout the ALU state is unknown, so clear it again before reuse.
          if (to_q) begin
            clr_cnt_d = '0;
            state_d   = StInit;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StRst;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRst;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      res_q      <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      res_q      <= res_d;
      to_q       <= to_d;
    end
  end

  assign alu_operation = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign rsp_result    = res_q;
  assign rsp_tag       = tag_q;
  assign rsp_timeout   = to_q;

endmodule
